// File: rtl/avg_pkg.sv
// Shared definitions for the temperature sample path: block-read FSM states
// and default geometry reused by the FIFO, averager and RAM stages.
package avg_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_BLK   = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DRAIN,
    DONE,
    HOLD
  } fsm_state_t;

endpackage

// File: rtl/fifo_mem.sv
// Circular sample buffer with occupancy tracking. Write and pop requests are
// qualified here; wr_ok/rd_ok report what actually happened this cycle.
module fifo_mem
  import avg_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             wr_ok,
  output logic             rd_ok,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write.
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // and count define which entries are valid, so stale contents are harmless.
  always_ff @(posedge clk_2) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/temp_fifo.sv
// Temperature sample FIFO feeding the averager in fixed-size blocks:
// request, drain BLK samples, signal completion, then wait for avg_done.
module temp_fifo
  import avg_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLK   = DEFAULT_BLK,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_fifo,
  input  logic             avg_done,
  output logic [WIDTH-1:0] fifo_to_avgr,
  output logic             rd_fifo,
  output logic             dis_rd_fifo,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int BLK_W = $clog2(BLK + 1);

  fsm_state_t       state;
  fsm_state_t       next_state;
  logic [BLK_W-1:0] blk_cnt;
  logic             blk_last;
  logic             pop_req;
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] head;

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .wr_en   (wr_fifo),
    .wr_data (data_in),
    .rd_en   (pop_req),
    .rd_data (head),
    .wr_ok   (wr_ok),
    .rd_ok   (rd_ok),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign blk_last = (blk_cnt == BLK_W'(BLK - 1));

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state  = state;
    rd_fifo     = 1'b0;
    dis_rd_fifo = 1'b0;
    pop_req     = 1'b0;
    case (state)
      IDLE:  if (count >= CNT_W'(BLK)) next_state = REQ;
      REQ: begin
        rd_fifo    = 1'b1;
        next_state = DRAIN;
      end
      DRAIN: begin
        pop_req = 1'b1;
        // A suppressed pop (empty FIFO) does not advance the block.
        if (rd_ok && blk_last) next_state = DONE;
      end
      DONE: begin
        dis_rd_fifo = 1'b1;
        next_state  = HOLD;
      end
      HOLD:  if (avg_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state        <= IDLE;
      blk_cnt      <= '0;
      fifo_to_avgr <= '0;
      overflow     <= 1'b0;
    end else begin
      state <= next_state;
      if (rd_ok) begin
        fifo_to_avgr <= head;
        blk_cnt      <= blk_last ? '0 : blk_cnt + BLK_W'(1);
      end
      if (wr_fifo && !wr_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_temp_fifo.sv
// Directed bench for temp_fifo: block reads, partial fill, overflow, HOLD
// gating, pointer wrap under concurrent write/pop, and reset mid-drain.
module tb_temp_fifo;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       wr_fifo;
  logic       avg_done;
  logic [7:0] fifo_to_avgr;
  logic       rd_fifo;
  logic       dis_rd_fifo;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_2 = ~clk_2;

  temp_fifo dut (
    .clk_2        (clk_2),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .wr_fifo      (wr_fifo),
    .avg_done     (avg_done),
    .fifo_to_avgr (fifo_to_avgr),
    .rd_fifo      (rd_fifo),
    .dis_rd_fifo  (dis_rd_fifo),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
  );

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic cyc();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    wr_fifo  = 1'b0;
    avg_done = 1'b0;
    data_in  = 8'h00;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic write_one(input logic [7:0] v);
    data_in = v;
    wr_fifo = 1'b1;
    cyc();
    wr_fifo = 1'b0;
  endtask

  // Waits for rd_fifo, checks a full block read of four samples, then
  // releases HOLD with an avg_done pulse, leaving the FSM in IDLE.
  task automatic expect_block(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3,
                              input string tag);
    logic [7:0] exp_d [4];
    logic       exp_dis;
    int         waited;
    exp_d  = '{d0, d1, d2, d3};
    waited = 0;
    while (rd_fifo !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    n_cmp++;
    if (rd_fifo !== 1'b1) begin
      n_err++;
      $display("FAIL %s_rd_fifo_wait: got %b after %0d cycles, required 1", tag, rd_fifo, waited);
    end
    cyc();
    n_cmp++;
    if (rd_fifo !== 1'b0) begin
      n_err++;
      $display("FAIL %s_rd_fifo_width: got %b, required 0", tag, rd_fifo);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      exp_dis = (k == 3);
      n_cmp++;
      if (fifo_to_avgr !== exp_d[k]) begin
        n_err++;
        $display("FAIL %s_data%0d: got %h, required %h", tag, k, fifo_to_avgr, exp_d[k]);
      end
      n_cmp++;
      if (dis_rd_fifo !== exp_dis) begin
        n_err++;
        $display("FAIL %s_dis%0d: got %b, required %b", tag, k, dis_rd_fifo, exp_dis);
      end
    end
    cyc();
    n_cmp++;
    if (dis_rd_fifo !== 1'b0) begin
      n_err++;
      $display("FAIL %s_dis_width: got %b, required 0", tag, dis_rd_fifo);
    end
    avg_done = 1'b1;
    cyc();
    avg_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    wr_fifo  = 1'b0;
    avg_done = 1'b0;
    data_in  = 8'h00;
    cyc();
    cyc();
    n_cmp++; if (count !== 4'd0)        begin n_err++; $display("FAIL reset_count: got %0d, required 0", count); end
    n_cmp++; if (empty !== 1'b1)        begin n_err++; $display("FAIL reset_empty: got %b, required 1", empty); end
    n_cmp++; if (full !== 1'b0)         begin n_err++; $display("FAIL reset_full: got %b, required 0", full); end
    n_cmp++; if (overflow !== 1'b0)     begin n_err++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    n_cmp++; if (fifo_to_avgr !== 8'h0) begin n_err++; $display("FAIL reset_data: got %h, required 00", fifo_to_avgr); end
    n_cmp++; if (rd_fifo !== 1'b0)      begin n_err++; $display("FAIL reset_rd_fifo: got %b, required 0", rd_fifo); end
    n_cmp++; if (dis_rd_fifo !== 1'b0)  begin n_err++; $display("FAIL reset_dis: got %b, required 0", dis_rd_fifo); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_block();
    do_reset();
    write_one(8'h10);
    write_one(8'h20);
    write_one(8'h30);
    write_one(8'h40);
    n_cmp++; if (count !== 4'd4)   begin n_err++; $display("FAIL basic_count4: got %0d, required 4", count); end
    n_cmp++; if (rd_fifo !== 1'b0) begin n_err++; $display("FAIL basic_rd_early: got %b, required 0", rd_fifo); end
    cyc();
    n_cmp++; if (rd_fifo !== 1'b1) begin n_err++; $display("FAIL basic_rd_timing: got %b, required 1", rd_fifo); end
    expect_block(8'h10, 8'h20, 8'h30, 8'h40, "basic");
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL basic_count0: got %0d, required 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty: got %b, required 1", empty); end
  endtask

  task automatic test_partial();
    do_reset();
    write_one(8'h31);
    write_one(8'h32);
    write_one(8'h33);
    n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL partial_count: got %0d, required 3", count); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL partial_empty: got %b, required 0", empty); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++; if (rd_fifo !== 1'b0) begin n_err++; $display("FAIL partial_no_rd%0d: got %b, required 0", i, rd_fifo); end
    end
    // avg_done outside HOLD must not disturb anything.
    avg_done = 1'b1;
    cyc();
    avg_done = 1'b0;
    n_cmp++; if (rd_fifo !== 1'b0) begin n_err++; $display("FAIL partial_avg_done_ignored: got %b, required 0", rd_fifo); end
    n_cmp++; if (count !== 4'd3)   begin n_err++; $display("FAIL partial_count_hold: got %0d, required 3", count); end
    write_one(8'h34);
    expect_block(8'h31, 8'h32, 8'h33, 8'h34, "partial");
  endtask

  // 13 back-to-back writes: first block drains samples 1..4, writes refill to
  // 8 (samples 5..12) and the 13th lands on a full FIFO in HOLD.
  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 13; i++) begin
      data_in = 8'(i);
      wr_fifo = 1'b1;
      cyc();
      if (i == 12) begin
        n_cmp++; if (count !== 4'd8)     begin n_err++; $display("FAIL ovf_fill_count: got %0d, required 8", count); end
        n_cmp++; if (full !== 1'b1)      begin n_err++; $display("FAIL ovf_full: got %b, required 1", full); end
        n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL ovf_early: got %b, required 0", overflow); end
      end
    end
    wr_fifo = 1'b0;
    n_cmp++; if (overflow !== 1'b1)     begin n_err++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    n_cmp++; if (count !== 4'd8)        begin n_err++; $display("FAIL ovf_count: got %0d, required 8", count); end
    n_cmp++; if (fifo_to_avgr !== 8'd4) begin n_err++; $display("FAIL ovf_last_pop: got %h, required 04", fifo_to_avgr); end
  endtask

  // Continues from test_overflow: FSM in HOLD with 8 entries.
  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++; if (rd_fifo !== 1'b0) begin n_err++; $display("FAIL hold_no_rd%0d: got %b, required 0", i, rd_fifo); end
    end
    avg_done = 1'b1;
    cyc();
    avg_done = 1'b0;
    n_cmp++; if (rd_fifo !== 1'b0) begin n_err++; $display("FAIL hold_idle_cycle: got %b, required 0", rd_fifo); end
    cyc();
    n_cmp++; if (rd_fifo !== 1'b1) begin n_err++; $display("FAIL hold_next_block: got %b, required 1", rd_fifo); end
  endtask

  // Continues from test_hold: FSM in REQ, FIFO full with 5..12, pointers at 4.
  task automatic test_wrap();
    logic [7:0] exp_v;
    cyc();
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL wrap_start_count: got %0d, required 8", count); end
    for (int k = 0; k < 4; k++) begin
      data_in = 8'hA0 + 8'(k);
      wr_fifo = 1'b1;
      cyc();
      exp_v = 8'd5 + 8'(k);
      n_cmp++; if (count !== 4'd8)        begin n_err++; $display("FAIL wrap_count%0d: got %0d, required 8", k, count); end
      n_cmp++; if (fifo_to_avgr !== exp_v) begin n_err++; $display("FAIL wrap_data%0d: got %h, required %h", k, fifo_to_avgr, exp_v); end
    end
    wr_fifo = 1'b0;
    n_cmp++; if (dis_rd_fifo !== 1'b1) begin n_err++; $display("FAIL wrap_dis: got %b, required 1", dis_rd_fifo); end
    cyc();
    avg_done = 1'b1;
    cyc();
    avg_done = 1'b0;
    expect_block(8'd9, 8'd10, 8'd11, 8'd12, "wrap_b2");
    expect_block(8'hA0, 8'hA1, 8'hA2, 8'hA3, "wrap_b3");
    n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL wrap_empty: got %b, required 1", empty); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL wrap_sticky_ovf: got %b, required 1", overflow); end
  endtask

  task automatic test_reset_mid_drain();
    int waited;
    do_reset();
    write_one(8'h11);
    write_one(8'h12);
    write_one(8'h13);
    write_one(8'h14);
    waited = 0;
    while (rd_fifo !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    n_cmp++; if (rd_fifo !== 1'b1) begin n_err++; $display("FAIL mid_rd_wait: got %b, required 1", rd_fifo); end
    cyc();
    cyc();
    n_cmp++; if (fifo_to_avgr !== 8'h11) begin n_err++; $display("FAIL mid_first_pop: got %h, required 11", fifo_to_avgr); end
    n_cmp++; if (count !== 4'd3)         begin n_err++; $display("FAIL mid_count3: got %0d, required 3", count); end
    reset_n = 1'b0;
    cyc();
    n_cmp++; if (count !== 4'd0)         begin n_err++; $display("FAIL mid_count0: got %0d, required 0", count); end
    n_cmp++; if (empty !== 1'b1)         begin n_err++; $display("FAIL mid_empty: got %b, required 1", empty); end
    n_cmp++; if (fifo_to_avgr !== 8'h00) begin n_err++; $display("FAIL mid_data: got %h, required 00", fifo_to_avgr); end
    n_cmp++; if (dis_rd_fifo !== 1'b0)   begin n_err++; $display("FAIL mid_dis: got %b, required 0", dis_rd_fifo); end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_cmp++; if (dis_rd_fifo !== 1'b0) begin n_err++; $display("FAIL mid_no_dis%0d: got %b, required 0", i, dis_rd_fifo); end
      n_cmp++; if (rd_fifo !== 1'b0)     begin n_err++; $display("FAIL mid_no_rd%0d: got %b, required 0", i, rd_fifo); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_partial();
    test_overflow();
    test_hold();
    test_wrap();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
